// File: rtl/game_if.sv
`default_nettype none
// ============================================================================
// game_if : player-group game control signals with controller/host modports
// Rev 1.0
// ============================================================================
interface game_if #(
  parameter int SCORE_W = 10
);
  logic               button_up;
  logic               crash;
  logic               game_tick;
  logic               countdown_en;
  logic               game_start_pulse;
  logic               game_over_pulse;
  logic               playing;
  logic               game_over;
  logic [SCORE_W-1:0] score;

  modport master (
    output button_up, crash,
    input  game_tick, countdown_en, game_start_pulse, game_over_pulse,
           playing, game_over, score
  );

  modport slave (
    input  button_up, crash,
    output game_tick, countdown_en, game_start_pulse, game_over_pulse,
           playing, game_over, score
  );
endinterface
`default_nettype wire

// File: rtl/game_state_controller.sv
`default_nettype none
// ============================================================================
// game_state_controller : IDLE/PLAYING/OVER sequencer, tick/debounce strobes, score
// Rev 1.0
// ============================================================================
module game_state_controller #(
  parameter int TICK_DIV = 50000,
  parameter int DEB_DIV  = 1000,
  parameter int HOLDOFF  = 32,
  parameter int SCORE_W  = 10
) (
  input  wire logic clk,
  input  wire logic reset_n,
  game_if.slave     bus
);
  localparam int c_PRE_W = $clog2(TICK_DIV);
  localparam int c_DEB_W = $clog2(DEB_DIV);
  localparam int c_HO_W  = $clog2(HOLDOFF + 1);

  localparam logic [c_PRE_W-1:0] c_PRE_MAX   = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_MAX   = c_DEB_W'(DEB_DIV - 1);
  localparam logic [c_HO_W-1:0]  c_HOLD      = c_HO_W'(HOLDOFF);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PLAYING = 2'd1;
  localparam logic [1:0] c_OVER    = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               r_btn_prev;
  logic               r_armed;
  logic [c_DEB_W-1:0] r_deb;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_HO_W-1:0]  r_hold;
  logic [SCORE_W-1:0] r_score;
  logic               r_tick;
  logic               r_cd;
  logic               r_start;
  logic               r_over;
  logic               w_rise;
  logic               w_wrap;
  logic               w_hold_done;
  logic               w_enter_play;
  logic               w_enter_over;
  logic               w_tick;

  // r_armed blocks a rise until the button has been seen low after reset
  assign w_rise      = bus.button_up & ~r_btn_prev & r_armed;
  assign w_wrap      = (r_pre == c_PRE_MAX);
  assign w_hold_done = (r_hold == c_HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = c_IDLE;
    case (r_state)
      c_IDLE:    w_next = w_rise ? c_PLAYING : c_IDLE;
      c_PLAYING: w_next = bus.crash ? c_OVER : c_PLAYING;
      c_OVER:    w_next = (w_rise && w_hold_done) ? c_PLAYING : c_OVER;
      default:   w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_enter_play = 1'b0;
    w_enter_over = 1'b0;
    w_tick       = 1'b0;
    w_enter_play = (w_next == c_PLAYING) && (r_state != c_PLAYING);
    w_enter_over = (w_next == c_OVER) && (r_state != c_OVER);
    // a crash coinciding with a wrap suppresses the tick
    w_tick       = w_wrap && (r_state == c_PLAYING) && !bus.crash;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev <= 1'b0;
      r_armed    <= 1'b0;
      r_deb      <= '0;
      r_cd       <= 1'b0;
      r_pre      <= '0;
      r_hold     <= '0;
      r_tick     <= 1'b0;
      r_start    <= 1'b0;
      r_over     <= 1'b0;
      r_score    <= '0;
    end else begin
      r_btn_prev <= bus.button_up;
      r_armed    <= r_armed | ~bus.button_up;

      r_deb <= (r_deb == c_DEB_MAX) ? '0 : r_deb + 1'b1;
      r_cd  <= (r_deb == c_DEB_MAX);

      if (w_enter_play || w_wrap) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      if (w_enter_over) begin
        r_hold <= '0;
      end else if ((r_state == c_OVER) && w_wrap && !w_hold_done) begin
        r_hold <= r_hold + 1'b1;
      end

      r_tick  <= w_tick;
      r_start <= w_enter_play;
      r_over  <= w_enter_over;

      if (w_enter_play) begin
        r_score <= '0;
      end else if (w_tick && (r_score != c_SCORE_MAX)) begin
        r_score <= r_score + 1'b1;
      end
    end
  end

  assign bus.game_tick        = r_tick;
  assign bus.countdown_en     = r_cd;
  assign bus.game_start_pulse = r_start;
  assign bus.game_over_pulse  = r_over;
  assign bus.playing          = (r_state == c_PLAYING);
  assign bus.game_over        = (r_state == c_OVER);
  assign bus.score            = r_score;
endmodule
`default_nettype wire

// File: tb/tb_game_state_controller.sv
`default_nettype none
// ============================================================================
// tb_game_state_controller : directed stimulus, event scoreboard with monitor
// Rev 1.0
// ============================================================================
module tb_game_state_controller;
  localparam int K_START = 0;
  localparam int K_TICK  = 1;
  localparam int K_OVER  = 2;

  typedef struct {
    int kind;
    int cyc;
    int score;
  } ev_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   errors;
  int   checks;
  ev_t  q[$];

  game_if #(.SCORE_W(4)) gif ();

  game_state_controller #(
    .TICK_DIV(4),
    .DEB_DIV (3),
    .HOLDOFF (2),
    .SCORE_W (4)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (gif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycles since reset release, matching the DUT's view of time
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cyc=%0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input int s);
    ev_t e;
    e.kind  = k;
    e.cyc   = c;
    e.score = s;
    q.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      int  kind;
      int  lvl;
      int  exp_lvl;
      ev_t e;
      checks++;
      if (gif.countdown_en !== ((cyc % 3 == 0) && (cyc != 0))) begin
        errors++;
        $display("FAIL countdown_en: got=%b expected=%b (cyc=%0d)",
                 gif.countdown_en, ((cyc % 3 == 0) && (cyc != 0)), cyc);
      end
      checks++;
      if (gif.playing && gif.game_over) begin
        errors++;
        $display("FAIL state_excl: playing=1 game_over=1 expected at most one (cyc=%0d)", cyc);
      end
      if (gif.game_start_pulse || gif.game_tick || gif.game_over_pulse) begin
        if (gif.game_start_pulse && !gif.game_tick && !gif.game_over_pulse)      kind = K_START;
        else if (gif.game_tick && !gif.game_start_pulse && !gif.game_over_pulse) kind = K_TICK;
        else if (gif.game_over_pulse && !gif.game_start_pulse && !gif.game_tick) kind = K_OVER;
        else                                                                     kind = 3;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind=%0d score=%0d at cyc=%0d, expected no event",
                   kind, gif.score, cyc);
        end else begin
          e       = q.pop_front();
          lvl     = (kind == K_OVER) ? int'(gif.game_over) : int'(gif.playing);
          exp_lvl = 1;
          if (kind != e.kind || cyc != e.cyc || int'(gif.score) != e.score || lvl != exp_lvl) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d score=%0d level=%0d expected kind=%0d cyc=%0d score=%0d level=1",
                     kind, cyc, gif.score, lvl, e.kind, e.cyc, e.score);
          end
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    gif.button_up = 1'b0;
    gif.crash     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          int'({gif.game_tick, gif.countdown_en, gif.game_start_pulse, gif.game_over_pulse,
                gif.playing, gif.game_over, gif.score}), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    wait_to(10);
    check("idle_playing", int'(gif.playing), 0);
    check("idle_score", int'(gif.score), 0);

    // game 1: run long enough to saturate, then crash on a wrap cycle
    gif.button_up = 1'b1;
    push(K_START, 11, 0);
    for (int k = 1; k <= 21; k++) push(K_TICK, 11 + 4 * k, (k > 15) ? 15 : k);
    wait_to(12);  gif.button_up = 1'b0;
    wait_to(98);  gif.crash = 1'b1;
    push(K_OVER, 99, 15);
    wait_to(100); gif.crash = 1'b0;
    check("over1_level", int'(gif.game_over), 1);
    check("over1_score", int'(gif.score), 15);

    // presses during holdoff are discarded; the third is accepted
    wait_to(101); gif.button_up = 1'b1;
    wait_to(103); gif.button_up = 1'b0;
    wait_to(104); check("holdoff_playing", int'(gif.playing), 0);
    wait_to(105); gif.button_up = 1'b1;
    wait_to(106); gif.button_up = 1'b0;
    wait_to(107); gif.button_up = 1'b1;
    push(K_START, 108, 0);
    push(K_TICK, 112, 1);
    push(K_TICK, 116, 2);
    push(K_TICK, 120, 3);
    wait_to(110); gif.button_up = 1'b0;
    wait_to(123); gif.crash = 1'b1;
    push(K_OVER, 124, 3);
    wait_to(125); gif.crash = 1'b0;
    wait_to(126);
    check("over2_score", int'(gif.score), 3);
    check("over2_level", int'(gif.game_over), 1);

    // game 3, interrupted by reset mid-play
    wait_to(134); gif.button_up = 1'b1;
    push(K_START, 135, 0);
    push(K_TICK, 139, 1);
    wait_to(136); gif.button_up = 1'b0;
    wait_to(141);
    gif.button_up = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          int'({gif.game_tick, gif.countdown_en, gif.game_start_pulse, gif.game_over_pulse,
                gif.playing, gif.game_over, gif.score}), 0);
    check("queue_drained_mid", q.size(), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // button held through release must not start a game
    wait_to(10);
    check("held_btn_playing", int'(gif.playing), 0);
    check("held_btn_over", int'(gif.game_over), 0);
    gif.button_up = 1'b0;
    wait_to(12); gif.button_up = 1'b1;
    push(K_START, 13, 0);
    push(K_TICK, 17, 1);
    wait_to(20);
    check("final_playing", int'(gif.playing), 1);
    check("queue_drained_end", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
